// File: rtl/multi_channel_write_engine.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_write_engine
// Purpose  : N-channel cache-line write engine. While the AFU runs it picks
//            round-robin among first-word-fall-through data FIFOs and streams
//            each channel to its own base address. On AFU_DONE it latches the
//            per-channel line counts. In AFU_CTRL it writes one status line
//            per channel at consecutive addresses starting at stts_addr_i.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk              system clock
//   reset            asynchronous active-high reset
//   stall_i          write-path backpressure (blocks new grants/issues)
//   afu_state_i      AFU state: 0 = CTRL, 1 = RUN, 2 = DONE, 3 = other
//   stts_addr_i      base cache-line address of the status block
//   wr_start_addr_i  per-channel stream base cache-line address
//   fifo_empty_i     per-channel FIFO empty flag
//   fifo_data_i      per-channel FIFO head data (FWFT)
//   fifo_rd_en_o     per-channel pop strobe, one-hot or zero
//   wr_valid_o       write request valid
//   wr_addr_o        write cache-line address
//   wr_data_o        write cache-line data
//   stts_done_o      one-cycle pulse after the last status line is issued
// Status line layout: bits [31:0] = STATUS_DONE (1), bits [32 +: CNT_W] =
// channel line count, all other bits zero.
// ============================================================================
module multi_channel_write_engine #(
  parameter int N_CHANNELS = 4,
  parameter int CNT_W      = 32,
  parameter int ADDR_W     = 42,
  parameter int DATA_W     = 512
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                stall_i,
  input  logic [1:0]                          afu_state_i,
  input  logic [ADDR_W-1:0]                   stts_addr_i,
  input  logic [N_CHANNELS-1:0][ADDR_W-1:0]   wr_start_addr_i,
  input  logic [N_CHANNELS-1:0]               fifo_empty_i,
  input  logic [N_CHANNELS-1:0][DATA_W-1:0]   fifo_data_i,
  output logic [N_CHANNELS-1:0]               fifo_rd_en_o,
  output logic                                wr_valid_o,
  output logic [ADDR_W-1:0]                   wr_addr_o,
  output logic [DATA_W-1:0]                   wr_data_o,
  output logic                                stts_done_o
);

  localparam int          IDX_W       = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam logic [1:0]  AFU_CTRL    = 2'd0;
  localparam logic [1:0]  AFU_RUN     = 2'd1;
  localparam logic [1:0]  AFU_DONE    = 2'd2;
  localparam logic [31:0] STATUS_DONE = 32'h0000_0001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SEND  = 2'd2,
    ST_FIN   = 2'd3
  } sts_state_t;

  // Channel index (base + k) modulo N_CHANNELS, for k in 0..N_CHANNELS.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_CHANNELS) s = s - N_CHANNELS;
    return IDX_W'(s);
  endfunction

  function automatic logic [DATA_W-1:0] status_line(input logic [CNT_W-1:0] cnt);
    logic [DATA_W-1:0] line;
    line             = '0;
    line[31:0]       = STATUS_DONE;
    line[32 +: CNT_W] = cnt;
    return line;
  endfunction

  logic [1:0]       state_q;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [CNT_W-1:0] offset_q [N_CHANNELS];
  logic [CNT_W-1:0] count_q  [N_CHANNELS];

  logic             grant_vld;
  logic [IDX_W-1:0] grant_idx;
  logic [ADDR_W-1:0] grant_addr;

  // stream stage 1
  logic              str_vld_q;
  logic [ADDR_W-1:0] str_addr_q;
  logic [DATA_W-1:0] str_data_q;

  // status path (FSM + its stage-1 register)
  sts_state_t        sts_state_q;
  logic [IDX_W-1:0]  sts_idx_q;
  logic              sts_vld_q;
  logic [ADDR_W-1:0] sts_addr_q;
  logic [DATA_W-1:0] sts_data_q;
  logic              stts_done_q;

  // output register
  logic              wr_valid_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= AFU_CTRL;
    else       state_q <= afu_state_i;
  end

  // Round-robin search: scan downward so the candidate closest to rr_q wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if ((state_q == AFU_RUN) && !stall_i) begin
      for (int k = N_CHANNELS - 1; k >= 0; k--) begin
        if (!fifo_empty_i[wrap_idx(rr_q, k)]) begin
          grant_vld = 1'b1;
          grant_idx = wrap_idx(rr_q, k);
        end
      end
    end
  end

  always_comb begin
    fifo_rd_en_o = '0;
    if (grant_vld) fifo_rd_en_o[grant_idx] = 1'b1;
  end

  assign rr_d       = grant_vld ? wrap_idx(grant_idx, 1) : rr_q;
  assign grant_addr = wr_start_addr_i[grant_idx] + ADDR_W'(offset_q[grant_idx]);

  // Offsets only advance in RUN, freeze in DONE (where counts track them)
  // and clear in every other state; counts survive until overwritten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q <= '0;
      for (int i = 0; i < N_CHANNELS; i++) begin
        offset_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int i = 0; i < N_CHANNELS; i++) begin
        if (state_q == AFU_RUN) begin
          if (grant_vld && (grant_idx == IDX_W'(i))) offset_q[i] <= offset_q[i] + CNT_W'(1);
        end else if (state_q == AFU_DONE) begin
          count_q[i] <= offset_q[i];
        end else begin
          offset_q[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      str_vld_q  <= 1'b0;
      str_addr_q <= '0;
      str_data_q <= '0;
    end else begin
      str_vld_q <= grant_vld;
      if (grant_vld) begin
        str_addr_q <= grant_addr;
        str_data_q <= fifo_data_i[grant_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sts_state_q <= ST_IDLE;
      sts_idx_q   <= '0;
      sts_vld_q   <= 1'b0;
      sts_addr_q  <= '0;
      sts_data_q  <= '0;
      stts_done_q <= 1'b0;
    end else begin
      sts_vld_q   <= 1'b0;
      stts_done_q <= 1'b0;
      case (sts_state_q)
        ST_IDLE: begin
          if (state_q == AFU_DONE) sts_state_q <= ST_ARMED;
        end
        ST_ARMED: begin
          if (state_q == AFU_CTRL) begin
            sts_state_q <= ST_SEND;
            sts_idx_q   <= '0;
          end
        end
        ST_SEND: begin
          // Leaving CTRL abandons the remaining lines without a done pulse.
          if (state_q != AFU_CTRL) begin
            sts_state_q <= ST_IDLE;
          end else if (!stall_i) begin
            sts_vld_q  <= 1'b1;
            sts_addr_q <= stts_addr_i + ADDR_W'(sts_idx_q);
            sts_data_q <= status_line(count_q[sts_idx_q]);
            if (sts_idx_q == IDX_W'(N_CHANNELS - 1)) sts_state_q <= ST_FIN;
            else                                     sts_idx_q   <= sts_idx_q + IDX_W'(1);
          end
        end
        ST_FIN: begin
          stts_done_q <= 1'b1;
          sts_state_q <= ST_IDLE;
        end
        default: sts_state_q <= ST_IDLE;
      endcase
    end
  end

  // The output mux follows the registered state at load time, so lines still
  // in stage 1 when the state changes are dropped rather than misrouted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      case (state_q)
        AFU_RUN: begin
          wr_valid_q <= str_vld_q;
          if (str_vld_q) begin
            wr_addr_q <= str_addr_q;
            wr_data_q <= str_data_q;
          end
        end
        AFU_CTRL: begin
          wr_valid_q <= sts_vld_q;
          if (sts_vld_q) begin
            wr_addr_q <= sts_addr_q;
            wr_data_q <= sts_data_q;
          end
        end
        default: wr_valid_q <= 1'b0;
      endcase
    end
  end

  assign wr_valid_o  = wr_valid_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign stts_done_o = stts_done_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_write_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_channel_write_engine
// Purpose  : Self-checking bench for multi_channel_write_engine (N=4, 4-bit
//            counters, 20-bit addresses, 64-bit lines). FIFOs, offsets, the
//            round-robin rule and the status block are modelled with queues
//            and plain arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_channel_write_engine;
  localparam int N  = 4;
  localparam int CW = 4;
  localparam int AW = 20;
  localparam int DW = 64;
  localparam int CNT_MOD = 1 << CW;
  localparam logic [1:0] S_CTRL = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   stall;
  logic [1:0]             afu_state;
  logic [AW-1:0]          stts_addr;
  logic [N-1:0][AW-1:0]   base;
  logic [N-1:0]           fifo_empty;
  logic [N-1:0][DW-1:0]   fifo_data;
  logic [N-1:0]           fifo_rd_en;
  logic                   wr_valid;
  logic [AW-1:0]          wr_addr;
  logic [DW-1:0]          wr_data;
  logic                   stts_done;

  always #5 clk = ~clk;

  multi_channel_write_engine #(
    .N_CHANNELS(N), .CNT_W(CW), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clk(clk), .reset(reset), .stall_i(stall), .afu_state_i(afu_state),
    .stts_addr_i(stts_addr), .wr_start_addr_i(base), .fifo_empty_i(fifo_empty),
    .fifo_data_i(fifo_data), .fifo_rd_en_o(fifo_rd_en), .wr_valid_o(wr_valid),
    .wr_addr_o(wr_addr), .wr_data_o(wr_data), .stts_done_o(stts_done)
  );

  typedef struct { int due; logic [AW-1:0] addr; logic [DW-1:0] data; } exp_t;

  logic [DW-1:0] fq [N][$];
  exp_t          sq[$];          // expected stream writes
  exp_t          tq[$];          // expected status writes, in order
  int            offs [N];
  int            cnt  [N];
  int            rr, cyc;
  bit            armed, stall_d1, stall_d2;
  logic [1:0]    st_q;
  int            sts_seen, done_seen;
  int            n_pass, n_fail, n_total;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifos();
    for (int i = 0; i < N; i++) begin
      fifo_empty[i] = (fq[i].size() == 0);
      fifo_data[i]  = (fq[i].size() > 0) ? fq[i][0] : '0;
    end
  endtask

  task automatic push_lines(input int ch, input int n);
    for (int k = 0; k < n; k++) fq[ch].push_back({$urandom, $urandom});
    drive_fifos();
  endtask

  function automatic bit fifos_busy();
    for (int i = 0; i < N; i++) if (fq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin offs[i] = 0; cnt[i] = 0; end
    rr = 0; armed = 1'b0; st_q = S_CTRL;
    sq.delete(); tq.delete();
  endtask

  // One clock cycle: check outputs at the falling edge, then update the model
  // and the FIFO inputs just after the rising edge.
  task automatic tick();
    logic [N-1:0] exp_rd;
    int g, c;
    @(negedge clk);
    exp_rd = '0;
    g = -1;
    if (!reset && st_q == S_RUN && !stall) begin
      for (int k = 0; k < N; k++) begin
        c = (rr + k) % N;
        if (g < 0 && fq[c].size() > 0) g = c;
      end
      if (g >= 0) exp_rd[g] = 1'b1;
    end
    check("rd_en", 64'(fifo_rd_en), 64'(exp_rd));
    if (sq.size() > 0 && sq[0].due == cyc) begin
      check("str_valid", 64'(wr_valid), 64'(1));
      check("str_addr", 64'(wr_addr), 64'(sq[0].addr));
      check("str_data", wr_data, sq[0].data);
      void'(sq.pop_front());
    end else if (wr_valid === 1'b1 && tq.size() > 0) begin
      check("sts_addr", 64'(wr_addr), 64'(tq[0].addr));
      check("sts_data", wr_data, tq[0].data);
      check("sts_issued_while_stalled", 64'(stall_d2), 64'(0));
      void'(tq.pop_front());
      sts_seen++;
    end else begin
      check("idle_valid", 64'(wr_valid), 64'(0));
    end
    if (stts_done === 1'b1) done_seen++;
    if (g >= 0) sq.push_back('{cyc + 2, base[g] + AW'(offs[g]), fq[g][0]});
    stall_d2 = stall_d1;
    stall_d1 = stall;
    @(posedge clk);
    #1;
    cyc++;
    if (g >= 0) begin
      void'(fq[g].pop_front());
      offs[g] = (offs[g] + 1) % CNT_MOD;
      rr = (g + 1) % N;
    end
    if (reset) begin
      model_reset();
    end else begin
      if (st_q == S_DONE) begin
        for (int i = 0; i < N; i++) cnt[i] = offs[i];
        armed = 1'b1;
      end else if (st_q != S_RUN) begin
        for (int i = 0; i < N; i++) offs[i] = 0;
      end
      if (st_q == S_CTRL && armed) begin
        for (int i = 0; i < N; i++)
          tq.push_back('{0, stts_addr + AW'(i), {32'(cnt[i]), 32'h1}});
        armed = 1'b0;
      end
      st_q = afu_state;
    end
    drive_fifos();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic drain(input bit rand_stall);
    int guard;
    guard = 0;
    while ((fifos_busy() || sq.size() > 0) && guard < 400) begin
      if (rand_stall) stall = ($urandom_range(0, 2) == 0);
      tick();
      guard++;
    end
    stall = 1'b0;
    if (guard >= 400) check("drain_timeout", 64'(guard), 64'(0));
    ticks(2);
  endtask

  // Accumulate counts in RUN, latch them in DONE, then collect the status block.
  task automatic status_round(input string tag, input bit rand_stall);
    int s0, d0;
    afu_state = S_DONE;
    ticks(2);
    s0 = sts_seen; d0 = done_seen;
    afu_state = S_CTRL;
    for (int k = 0; k < 30; k++) begin
      if (rand_stall) stall = ~stall;
      tick();
    end
    stall = 1'b0;
    ticks(4);
    check({tag, "_lines"}, 64'(sts_seen - s0), 64'(N));
    check({tag, "_done"}, 64'(done_seen - d0), 64'(1));
    check({tag, "_pending"}, 64'(tq.size()), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0;
    n_pass = 0; n_fail = 0; n_total = 0; cyc = 0;
    sts_seen = 0; done_seen = 0; stall_d1 = 0; stall_d2 = 0;
    model_reset();
    reset = 1'b1; stall = 1'b0; afu_state = S_CTRL; stts_addr = 20'h08000;
    base[0] = 20'h01000; base[1] = 20'h02000; base[2] = 20'h03000; base[3] = 20'h04000;
    drive_fifos();
    ticks(2);
    check("rst_wr_valid", 64'(wr_valid), 64'(0));
    check("rst_wr_addr", 64'(wr_addr), 64'(0));
    check("rst_wr_data", wr_data, 64'(0));
    check("rst_rd_en", 64'(fifo_rd_en), 64'(0));
    check("rst_stts_done", 64'(stts_done), 64'(0));
    reset = 1'b0;
    ticks(2);

    // Four channels, three lines each: strict ch0..ch3 rotation.
    for (int i = 0; i < N; i++) push_lines(i, 3);
    afu_state = S_RUN;
    drain(1'b0);

    // Only channel 2 has data.
    afu_state = S_CTRL; ticks(3);
    push_lines(2, 5);
    afu_state = S_RUN;
    drain(1'b0);

    // 10-line burst stalled for 4 cycles starting at its third cycle.
    afu_state = S_CTRL; ticks(3);
    push_lines(1, 10);
    afu_state = S_RUN;
    ticks(2);
    stall = 1'b1; ticks(4); stall = 1'b0;
    drain(1'b0);

    // Counts 3,0,7,1 reported in the status block.
    afu_state = S_CTRL; ticks(3);
    push_lines(0, 3); push_lines(2, 7); push_lines(3, 1);
    afu_state = S_RUN;
    drain(1'b0);
    status_round("sts_basic", 1'b0);
    s0 = sts_seen; d0 = done_seen;
    afu_state = S_RUN; ticks(3);
    afu_state = S_CTRL; ticks(10);
    check("rearm_lines", 64'(sts_seen - s0), 64'(0));
    check("rearm_done", 64'(done_seen - d0), 64'(0));

    // Stall toggled every cycle while the status block is sent.
    afu_state = S_RUN;
    push_lines(1, 2); push_lines(3, 4);
    drain(1'b0);
    status_round("sts_toggle", 1'b1);

    // Leave CTRL after two status lines.
    afu_state = S_RUN;
    push_lines(0, 1);
    drain(1'b0);
    afu_state = S_DONE; ticks(2);
    s0 = sts_seen; d0 = done_seen;
    afu_state = S_CTRL; stall = 1'b1;
    ticks(2);
    stall = 1'b0;
    ticks(2);
    stall = 1'b1; afu_state = S_RUN;
    ticks(6);
    stall = 1'b0;
    check("abort_lines", 64'(sts_seen - s0), 64'(2));
    check("abort_done", 64'(done_seen - d0), 64'(0));
    tq.delete();
    afu_state = S_CTRL; ticks(8);
    check("abort_no_resend", 64'(sts_seen - s0), 64'(2));

    // Offset wrap (4-bit counter) and address wrap near the top of the space.
    afu_state = S_CTRL; ticks(3);
    base[0] = 20'hFFFF8;
    push_lines(0, 17);
    afu_state = S_RUN;
    drain(1'b0);

    // Randomised rounds: random bases, fills and stalls, then a status block.
    for (int r = 0; r < 6; r++) begin
      afu_state = S_CTRL; ticks(3);
      for (int i = 0; i < N; i++) base[i] = AW'($urandom);
      stts_addr = (r == 5) ? 20'hFFFFE : AW'($urandom);
      for (int i = 0; i < N; i++) push_lines(i, $urandom_range(0, 9));
      afu_state = S_RUN;
      ticks($urandom_range(1, 4));
      push_lines($urandom_range(0, N - 1), $urandom_range(1, 5));
      drain(1'b1);
      status_round("sts_random", r[0]);
    end

    // Asynchronous reset in the middle of a burst.
    afu_state = S_CTRL; ticks(3);
    push_lines(3, 12);
    afu_state = S_RUN;
    ticks(4);
    #2;
    reset = 1'b1;
    #1;
    check("arst_wr_valid", 64'(wr_valid), 64'(0));
    check("arst_wr_addr", 64'(wr_addr), 64'(0));
    check("arst_wr_data", wr_data, 64'(0));
    check("arst_rd_en", 64'(fifo_rd_en), 64'(0));
    model_reset();
    ticks(3);
    reset = 1'b0;
    drain(1'b0);
    check("arst_fifo_left", 64'(fq[3].size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
